// File: rtl/fir_cfg_pkg.sv
// FIR configuration master: shared address map, ap_ctrl bits
// and sequencer state encoding.
package fir_cfg_pkg;

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_LEN  = 8'h10;
  localparam logic [7:0] ADDR_TAP0 = 8'h20;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_TAP,
    S_WR_START,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

endpackage

// File: rtl/fir_cfg_master_if.sv
// AXI-Lite bundle between the configuration master and the FIR
// register slave.
interface fir_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata,
    output arvalid, araddr, rready,
    input  awready, wready, arready,
    input  rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata,
    input  arvalid, araddr, rready,
    output awready, wready, arready,
    output rvalid, rdata
  );
endinterface

// File: rtl/axil_wr_issuer.sv
// One AXI-Lite write: AW and W channels retire independently,
// complete pulses in the cycle the last one handshakes.
module axil_wr_issuer #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   issue,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   active,
  output logic                   complete
);

  logic aw_left;
  logic w_left;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
    end else if (issue) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= addr;
      wdata   <= data;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
    end
  end

  assign aw_left  = awvalid && !awready;
  assign w_left   = wvalid && !wready;
  assign active   = awvalid || wvalid;
  assign complete = active && !aw_left && !w_left;

endmodule

// File: rtl/fir_cfg_master.sv
// Programs length and taps into the FIR over AXI-Lite, starts it
// and polls ap_ctrl until ap_done.
module fir_cfg_master
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_start,
  input  logic [31:0]            cmd_length,
  output logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_data,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  fir_cfg_master_if.master       axil
);

  state_t                 state_q, state_d;
  logic [31:0]            len_q;
  logic [3:0]             idx_q;
  logic [2:0]             status_q;
  logic                   issue;
  logic                   wr_act;
  logic                   wr_cmpl;
  logic                   tap_last;
  logic [7:0]             wr_off;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic                   unused_rd;

  assign tap_last  = idx_q == 4'(pTAP_NUM - 1);
  assign unused_rd = ^axil.rdata[pDATA_WIDTH-1:3];

  always_comb begin
    wr_off           = ADDR_CTRL;
    wr_data          = '0;
    wr_data[AP_START] = 1'b1;
    unique case (1'b1)
      (state_q == S_WR_LEN): begin
        wr_off  = ADDR_LEN;
        wr_data = pDATA_WIDTH'(len_q);
      end
      (state_q == S_WR_TAP): begin
        wr_off  = ADDR_TAP0 + {2'b00, idx_q, 2'b00};
        wr_data = tap_data;
      end
      default: ;
    endcase
  end

  axil_wr_issuer #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_wr (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .issue     (issue),
    .addr      (pADDR_WIDTH'(wr_off)),
    .data      (wr_data),
    .awvalid   (axil.awvalid),
    .awready   (axil.awready),
    .awaddr    (axil.awaddr),
    .wvalid    (axil.wvalid),
    .wready    (axil.wready),
    .wdata     (axil.wdata),
    .active    (wr_act),
    .complete  (wr_cmpl)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_start)
        len_q <= cmd_length;
      if (state_q == S_WR_TAP && wr_cmpl)
        idx_q <= tap_last ? 4'd0 : idx_q + 4'd1;
      if (state_q == S_RD_DATA && axil.rvalid)
        status_q <= axil.rdata[2:0];
    end
  end

  // A new write is issued only once the previous one has fully retired.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (cmd_start) state_d = S_WR_LEN;
      S_WR_LEN: begin
        issue = !wr_act;
        if (wr_cmpl) state_d = S_WR_TAP;
      end
      S_WR_TAP: begin
        issue = !wr_act;
        if (wr_cmpl && tap_last) state_d = S_WR_START;
      end
      S_WR_START: begin
        issue = !wr_act;
        if (wr_cmpl) state_d = S_RD_ADDR;
      end
      S_RD_ADDR:
        if (axil.arready) state_d = S_RD_DATA;
      S_RD_DATA:
        if (axil.rvalid)
          state_d = axil.rdata[AP_DONE] ? S_DONE : S_RD_ADDR;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  assign axil.arvalid = state_q == S_RD_ADDR;
  assign axil.araddr  = pADDR_WIDTH'(ADDR_CTRL);
  assign axil.rready  = state_q == S_RD_DATA;
  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign status       = status_q;
  assign tap_idx      = idx_q;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master with an AXI-Lite slave model
// and a write scoreboard.
module tb_fir_cfg_master;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        cmd_start;
  logic [31:0] cmd_length;
  logic [3:0]  tap_idx;
  logic [31:0] tap_data;
  logic        busy;
  logic        done;
  logic [2:0]  status;

  fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axil ();

  fir_cfg_master #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .pTAP_NUM   (11)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .cmd_start (cmd_start),
    .cmd_length(cmd_length),
    .tap_idx   (tap_idx),
    .tap_data  (tap_data),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .axil      (axil.master)
  );

  int total = 0;
  int bad   = 0;

  int mode       = 0;
  int polls_left = 0;
  int rd_cnt     = 0;
  int done_cnt   = 0;
  int wcnt       = 0;
  bit rpend      = 0;
  bit aw_just    = 0;
  bit p_aw, p_aw_hs, p_w, p_w_hs;
  logic [11:0] p_awaddr;
  logic [31:0] p_wdata;

  logic [11:0] q_aw[$];
  logic [31:0] q_w[$];
  logic [43:0] q_exp[$];

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  function automatic logic [31:0] tap_val(input logic [3:0] i);
    return 32'hA500_0000 | (32'(i) * 32'h0101 + 32'd7);
  endfunction

  assign tap_data = tap_val(tap_idx);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] len);
    q_exp.push_back({12'h010, len});
    for (int i = 0; i < 11; i++)
      q_exp.push_back({12'(32'h20 + 4 * i), tap_val(4'(i))});
    q_exp.push_back({12'h000, 32'h1});
  endtask

  // AXI-Lite slave model and monitors, all on the falling edge
  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      axil.awready = 1'b0;
      axil.wready  = 1'b0;
      axil.arready = 1'b0;
      axil.rvalid  = 1'b0;
      rpend = 0; wcnt = 0; aw_just = 0;
      p_aw = 0; p_aw_hs = 0; p_w = 0; p_w_hs = 0;
    end else begin
      if (aw_just) begin
        chk("aw_drop", 64'(axil.awvalid), 64'd0);
        chk("w_hold", 64'(axil.wvalid), 64'd1);
        aw_just = 0;
      end
      if (p_aw && !p_aw_hs && axil.awvalid)
        chk("awaddr_stable", 64'(axil.awaddr), 64'(p_awaddr));
      if (p_w && !p_w_hs && axil.wvalid)
        chk("wdata_stable", 64'(axil.wdata), 64'(p_wdata));

      if (mode == 1) begin
        axil.wready = 1'b0;
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) axil.wready = 1'b1;
        end
        axil.awready = axil.awvalid;
      end else if (mode == 2) begin
        axil.awready = !(axil.awvalid && axil.awaddr == 12'h028);
        axil.wready  = axil.awready;
      end else begin
        axil.awready = 1'b1;
        axil.wready  = 1'b1;
      end

      axil.rvalid = 1'b0;
      if (rpend) begin
        axil.rvalid = 1'b1;
        axil.rdata  = (polls_left > 0) ? 32'h0 : 32'h6;
        if (polls_left > 0) polls_left--;
        rpend = 0;
      end
      axil.arready = axil.arvalid;
      if (axil.arvalid) begin
        rd_cnt++;
        rpend = 1;
        chk("araddr", 64'(axil.araddr), 64'd0);
      end
      if (axil.arvalid || axil.rready)
        chk("tap_idx_rd", 64'(tap_idx), 64'd0);
      chk("ar_excl",
          64'(axil.arvalid && (axil.awvalid || axil.wvalid)), 64'd0);

      p_aw_hs = axil.awvalid && axil.awready;
      p_w_hs  = axil.wvalid && axil.wready;
      p_aw = axil.awvalid; p_awaddr = axil.awaddr;
      p_w  = axil.wvalid;  p_wdata  = axil.wdata;
      if (p_aw_hs) begin
        q_aw.push_back(axil.awaddr);
        if (mode == 1) begin wcnt = 3; aw_just = 1; end
      end
      if (p_w_hs) q_w.push_back(axil.wdata);
      if (q_aw.size() > 0 && q_w.size() > 0) begin
        logic [11:0] a;
        logic [31:0] d;
        a = q_aw.pop_front();
        d = q_w.pop_front();
        if (q_exp.size() == 0) begin
          total++; bad++;
          $error("FAIL wr_extra: got %h=%h want none", a, d);
        end else begin
          chk("wr", 64'({a, d}), 64'(q_exp.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic start(input logic [31:0] len, input int polls,
                       input int m);
    mode = m; polls_left = polls; rd_cnt = 0; done_cnt = 0;
    push_exp(len);
    cmd_length = len;
    cmd_start  = 1'b1;
    @(negedge axis_clk);
    cmd_start  = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int exp_rd);
    int n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(negedge axis_clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 600), 64'd1);
    @(negedge axis_clk);
    @(negedge axis_clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_lo"}, 64'(done), 64'd0);
    chk({tag, "_status"}, 64'(status), 64'h6);
    chk({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
    chk({tag, "_exp_left"}, 64'(q_exp.size()), 64'd0);
  endtask

  initial begin
    axis_rst_n   = 1'b0;
    cmd_start    = 1'b0;
    cmd_length   = '0;
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    axil.arready = 1'b0;
    axil.rvalid  = 1'b0;
    axil.rdata   = '0;
    repeat (2) @(negedge axis_clk);
    chk("rst_awvalid", 64'(axil.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axil.wvalid), 64'd0);
    chk("rst_arvalid", 64'(axil.arvalid), 64'd0);
    chk("rst_rready", 64'(axil.rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_tap_idx", 64'(tap_idx), 64'd0);
    axis_rst_n = 1'b1;
    repeat (2) @(negedge axis_clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_awvalid", 64'(axil.awvalid), 64'd0);

    start(32'd64, 0, 0);
    finish_run("basic", 1);

    start(32'h0000_1234, 0, 1);
    finish_run("split_hs", 1);

    start(32'd0, 5, 0);
    finish_run("polls", 6);

    start(32'd100, 0, 0);
    begin
      int n = 0;
      while (tap_idx != 4'd4 && n < 200) begin
        @(negedge axis_clk);
        n++;
      end
      chk("repulse_reach", 64'(n < 200), 64'd1);
    end
    cmd_length = 32'd999;
    cmd_start  = 1'b1;
    @(negedge axis_clk);
    cmd_start  = 1'b0;
    finish_run("repulse", 1);

    start(32'd55, 0, 2);
    begin
      int n = 0;
      while (!(tap_idx == 4'd2 && axil.awvalid) && n < 200) begin
        @(negedge axis_clk);
        n++;
      end
      chk("stall_reach", 64'(n < 200), 64'd1);
    end
    #1 axis_rst_n = 1'b0;
    #1;
    chk("mid_rst_awvalid", 64'(axil.awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(axil.wvalid), 64'd0);
    chk("mid_rst_arvalid", 64'(axil.arvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tap_idx", 64'(tap_idx), 64'd0);
    q_exp.delete();
    q_aw.delete();
    q_w.delete();
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    start(32'd7, 1, 0);
    finish_run("restart", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_cfg_master.md
FIR_CFG_MASTER -- requirements
Module: fir_cfg_master

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter pTAP_NUM, default 11, number of coefficients programmed.
REQ-004 SHALL have one clock and an asynchronous active-low reset: axis_clk  in  1  clock; axis_rst_n  in  1  reset.
REQ-005 SHALL have cmd_start  in  1  single-cycle request to run one configure/start/poll sequence.
REQ-006 SHALL have cmd_length  in  32  value written to the data_length register.
REQ-007 SHALL have tap_idx  out  4 and tap_data  in  pDATA_WIDTH: coefficient lookup, same-cycle combinational response.
REQ-008 SHALL have awvalid out 1, awready in 1, awaddr out pADDR_WIDTH, wvalid out 1, wready in 1, wdata out pDATA_WIDTH.
REQ-009 SHALL have arvalid out 1, arready in 1, araddr out pADDR_WIDTH, rvalid in 1, rready out 1, rdata in pDATA_WIDTH.
REQ-010 SHALL have busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse; status  out  3  last ap_ctrl bits [2:0] read.

Function
REQ-011 SHALL use the address map 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle), 0x10 data_length, 0x20+4*i tap i.
REQ-012 SHALL implement states IDLE, WR_LEN, WR_TAP, WR_START, RD_ADDR, RD_DATA, DONE.
REQ-013 SHALL move IDLE->WR_LEN on cmd_start=1 and SHALL ignore cmd_start in every other state.
REQ-014 SHALL, on each write, assert awvalid and wvalid in the same cycle, drop each independently on its own valid&ready cycle, and leave the state only once both handshakes have completed (same or different cycles).
REQ-015 SHALL hold awaddr/wdata stable while the corresponding valid is high.
REQ-016 SHALL write cmd_length (captured at cmd_start) to 0x10 in WR_LEN, then enter WR_TAP with tap_idx=0.
REQ-017 SHALL write tap_data to 0x20+4*tap_idx in WR_TAP, increment tap_idx after each completed write, and enter WR_START after index pTAP_NUM-1.
REQ-018 SHALL write 32'h1 to 0x00 in WR_START, then enter RD_ADDR.
REQ-019 SHALL assert arvalid with araddr=0x00 in RD_ADDR until arready, then enter RD_DATA with rready=1.
REQ-020 SHALL, on rvalid in RD_DATA, load status<=rdata[2:0]; if rdata[1]=1 go to DONE, else return to RD_ADDR next cycle.
REQ-021 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE; busy=1 in all states except IDLE.
REQ-022 SHALL never assert arvalid while awvalid or wvalid is high.
REQ-023 SHALL accept cmd_length=0 and write it unchanged.
REQ-024 SHALL drive tap_idx=0 outside WR_TAP.

Reset
REQ-025 SHALL, while axis_rst_n=0, immediately force state IDLE and awvalid, wvalid, arvalid, rready, busy, done, status, tap_idx to 0, including mid-transaction.
REQ-026 SHALL start no transaction in the first cycle after reset release unless cmd_start=1 in that cycle.

Structure
REQ-027 SHALL take address constants (0x00, 0x10, 0x20), ap_ctrl bit positions and the state encoding from shared package fir_cfg_pkg.
REQ-028 SHALL place the independent AW/W handshake tracking in one sub-module axil_wr_issuer (inputs: issue, addr, data; output: complete pulse).

Verification
REQ-029 SHALL cover: cmd_start, cmd_length=64, awready=wready=1 always -> writes 0x10=64, 0x20..0x48 taps 0..10, 0x00=1, then reads; rdata=0x6 on first read -> done one cycle later, status=3'b110.
REQ-030 SHALL cover: wready 3 cycles after awready on each write -> no write lost or duplicated, awvalid drops after its handshake, wvalid holds until wready.
REQ-031 SHALL cover: rdata=0x0 for 5 polls then 0x6 -> exactly 6 reads to 0x00, done pulses once, busy low afterwards.
REQ-032 SHALL cover: cmd_start re-pulsed during WR_TAP -> ignored; tap sequence continues unchanged.
REQ-033 SHALL cover: axis_rst_n low while awvalid=1 in WR_TAP -> all valids 0 within the reset cycle, state IDLE; next cmd_start restarts from WR_LEN.
